mem_port_arbiter: RTL

//  Shares the single unified memory port between instruction fetch (IF) and load/store (LS).

---
 rtl/mem_bus_pkg.sv | 5 +
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types for the unified memory port arbiter
package mem_bus_pkg;
    typedef enum logic {ARB, WAIT} arb_state_t;
    typedef enum logic {REQ_IF, REQ_LS} requester_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, LS priority with fetch streak limit
module mem_port_arbiter
    import mem_bus_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [WIDTH-1:0]   if_addr,
    output logic               if_gnt,
    output logic               if_rvalid,
    output logic [WIDTH-1:0]   if_rdata,
    input  logic               ls_req,
    input  logic               ls_we,
    input  logic [WIDTH-1:0]   ls_addr,
    input  logic [WIDTH-1:0]   ls_wdata,
    input  logic [WIDTH/8-1:0] ls_be,
    output logic               ls_gnt,
    output logic               ls_rvalid,
    output logic [WIDTH-1:0]   ls_rdata,
    output logic               mem_req,
    output logic               mem_we,
    output logic [WIDTH-1:0]   mem_addr,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic [WIDTH/8-1:0] mem_be,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [WIDTH-1:0]   mem_rdata
);
    localparam int SW = $clog2(MAX_STREAK + 1);

    arb_state_t       state, state_nxt;
    requester_t       sel, lock_sel, owner;
    logic             lock;
    logic [SW-1:0]    streak;
    logic             grant;
    logic             if_pend, ls_pend, rst_seen;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= ARB;
        else state <= state_nxt;
    end

    // next state: one accepted transaction moves to WAIT, its response returns to ARB
    always_comb begin
        state_nxt = state;
        if (state == ARB && grant) state_nxt = WAIT;
        if (state == WAIT && mem_rvalid) state_nxt = ARB;
    end

    // selection, memory-side muxing, grant and response pulses
    always_comb begin
        sel       = lock ? lock_sel
                  : (ls_req && !(if_req && streak == SW'(MAX_STREAK))) ? REQ_LS : REQ_IF;
        mem_req   = !rst && state == ARB && (if_req || ls_req);
        mem_we    = sel == REQ_LS ? ls_we : 1'b0;
        mem_addr  = sel == REQ_LS ? ls_addr : if_addr;
        mem_wdata = ls_wdata;
        mem_be    = sel == REQ_LS ? ls_be : '1;
        grant     = mem_req && mem_gnt;
        if_gnt    = grant && sel == REQ_IF;
        ls_gnt    = grant && sel == REQ_LS;
        if_rvalid = !rst && state == WAIT && mem_rvalid && owner == REQ_IF;
        ls_rvalid = !rst && state == WAIT && mem_rvalid && owner == REQ_LS;
        if_rdata  = mem_rdata;
        ls_rdata  = mem_rdata;
    end

    // lock holds an offered-but-unaccepted selection; owner and streak update on grant
    always_ff @(posedge clk) begin
        if (rst) begin
            lock     <= 1'b0;
            lock_sel <= REQ_IF;
            owner    <= REQ_IF;
            streak   <= '0;
        end else if (grant) begin
            lock  <= 1'b0;
            owner <= sel;
            if (sel == REQ_IF || !if_req) streak <= '0;
            else if (streak != SW'(MAX_STREAK)) streak <= streak + 1'b1;
        end else if (mem_req) begin
            lock     <= 1'b1;
            lock_sel <= sel;
        end
    end

    // simulation-only protocol checks
    always_ff @(posedge clk) begin
        if (rst) begin
            if_pend  <= 1'b0;
            ls_pend  <= 1'b0;
            rst_seen <= 1'b1;
        end else begin
            if_pend <= if_req && !if_gnt;
            ls_pend <= ls_req && !ls_gnt;
            if (grant) rst_seen <= 1'b0;
            assert (!if_pend || if_req);
            assert (!ls_pend || ls_req);
            assert (!(state == ARB && mem_rvalid) || rst_seen);
            assert (!(if_gnt && ls_gnt));
        end
    end
endmodule
